mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single four-bank main memory between the instruction-cache controller (port I) and the data-cache controller (port D).
- Picks one requester at a time and drives the memory read/write strobe for one cycle. Tracks bank busy and the read latency, then returns read data to the winning requester.
- Sits between the two cache controllers' mem_rd/mem_wr outputs and the banked memory model.

Parameters:
- RD_LAT, 2, cycles from the read strobe to valid mem_rdata (legal 1..7).
- STARVE_LIM, 4, consecutive lost arbitration cycles after which port I gets priority (legal 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  port I request; held until i_gnt.
- i_wr  in  1  port I: 1 = write, 0 = read.
- i_addr  in  16  port I word address.
- i_wdata  in  16  port I write data.
- i_gnt  out  1  pulse: port I request accepted.
- i_rvalid  out  1  pulse: i_rdata valid.
- i_rdata  out  16  port I read data.
- i_err  out  1  pulse with i_gnt when memory flags an error.
- d_req, d_wr, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: same as the port I signals, for port D.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_busy  in  4  per-bank busy flags.
- mem_err  in  1  memory error, sampled in the strobe cycle.

Behaviour:
- Bank selection: bank = addr[2:1]. A candidate is eligible when its req=1 and mem_busy[bank]=0.
- Reset (rst=0, async): state=IDLE; starve_cnt=0; owner=D; all outputs 0, including rdata.
- States: IDLE, RD_WAIT, RD_RESP.
- Arbitration, combinational in IDLE:
  - Port D wins by default.
  - Port I wins if only port I is eligible, or if both are eligible and starve_cnt >= STARVE_LIM.
  - If the preferred port is ineligible because its bank is busy, the other eligible port wins. There is no idle cycle wasted on a busy bank.
- IDLE, winner exists (issue cycle):
  - Drive mem_addr/mem_wdata from the winner.
  - Assert mem_wr if the winner's wr=1, otherwise mem_rd, for exactly this cycle.
  - Assert the winner's gnt for this cycle; assert its err in the same cycle if mem_err=1. Register owner.
  - Write: stay IDLE (one-cycle transaction).
  - Read with mem_err=1: stay IDLE; no rvalid.
  - Read with mem_err=0: go to RD_WAIT and load lat_cnt=RD_LAT-1.
- IDLE, no eligible winner: no strobes; stay IDLE.
- mem_addr/mem_wdata equal 0 whenever no strobe is asserted.
- RD_WAIT:
  - No strobes; no new grants; requests stay pending.
  - Decrement lat_cnt each cycle; when lat_cnt=0, capture mem_rdata into the owner's rdata register and go to RD_RESP.
  - With RD_LAT=1, RD_WAIT lasts exactly one cycle.
- RD_RESP:
  - Owner's rvalid=1 for one cycle; go to IDLE.
  - rdata holds until the next capture.
  - End-to-end: rvalid is asserted RD_LAT+1 cycles after the gnt cycle.
- starve_cnt:
  - Increments, saturating at 15, on each IDLE issue cycle where i_req=1 and port I does not win.
  - Clears to 0 when port I wins.
  - Holds in RD_WAIT and RD_RESP.
- Requests dropped before gnt are legal and ignored. Requests arriving in RD_WAIT/RD_RESP wait for IDLE.
- Reset mid-read: the transaction is abandoned; no rvalid after reset.
- Never asserts mem_rd and mem_wr together; never asserts both gnts in one cycle.

Test Plan:
- Port D read of 0x0010 only, mem_rdata=0xBEEF, RD_LAT=2 -> d_gnt and mem_rd at cycle t, d_rvalid with d_rdata=0xBEEF at t+3, i_* outputs stay 0.
- i_req and d_req both held continuously, both reads, distinct non-busy banks -> D wins the first 4 arbitrations, I wins the 5th, starve_cnt returns to 0, then D wins again.
- d_req to bank 1 with mem_busy=4'b0010, i_req write to bank 0 -> same cycle: i_gnt=1, mem_wr=1, mem_addr=i_addr; D is granted the first IDLE cycle after mem_busy[1] clears.
- Port I write with mem_err=1 -> i_gnt=1 and i_err=1 in the same cycle, no i_rvalid, arbiter back in IDLE next cycle.
- Port D read granted, rst pulled low during RD_WAIT -> all outputs 0 immediately, no d_rvalid after rst releases, next request is served normally.
- RD_LAT=1, back-to-back D reads 0x0002/0x0004 (bank 1, bank 2) -> grants 3 cycles apart, each d_rvalid 2 cycles after its gnt with the correct data.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the four-bank main memory between the instruction-cache
// port (I) and the data-cache port (D). One request is issued at a time. A read
// holds the arbiter until its data has been returned to the requester. Port D
// is preferred, but port I takes over once it has lost STARVE_LIM arbitrations.
module mem_arbiter #(
  parameter int RD_LAT     = 2,  // read strobe to valid mem_rdata, 1..7
  parameter int STARVE_LIM = 4   // lost arbitrations before port I is preferred, 1..15
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low

  input  logic        i_req,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [15:0] i_rdata,
  output logic        i_err,

  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        d_err,

  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic [3:0]  mem_busy,
  input  logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(RD_LAT - 1);
  localparam logic [3:0] STARVE_THR = 4'(STARVE_LIM);
  localparam logic [3:0] STARVE_MAX = 4'd15;

  state_t      state_reg, state_next;
  logic [2:0]  lat_cnt_reg, lat_cnt_next;
  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic        owner_i_reg, owner_i_next;      // 1 = port I owns the read, 0 = port D
  logic [15:0] i_rdata_reg, i_rdata_next;
  logic [15:0] d_rdata_reg, d_rdata_next;

  // Per-bank busy hit for each requester; bank = addr[2:1].
  logic [3:0] i_bank_hit, d_bank_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    assign i_bank_hit[gi] = (i_addr[2:1] == 2'(gi)) & mem_busy[gi];
    assign d_bank_hit[gi] = (d_addr[2:1] == 2'(gi)) & mem_busy[gi];
  end

  logic i_elig, d_elig, starving, i_win, d_win;

  assign i_elig   = i_req & ~(|i_bank_hit);
  assign d_elig   = d_req & ~(|d_bank_hit);
  assign starving = (starve_cnt_reg >= STARVE_THR);

  // Winner select. A busy preferred port falls through to the other eligible
  // port in the same cycle. Gated by rst so that nothing is issued while the
  // arbiter is held in reset.
  assign i_win = rst & i_elig & (~d_elig | starving);
  assign d_win = rst & d_elig & ~i_win;

  // Winner's transaction fields, used only in an issue cycle.
  logic        sel_wr;
  logic [15:0] sel_addr, sel_wdata;

  assign sel_wr    = i_win ? i_wr    : d_wr;
  assign sel_addr  = i_win ? i_addr  : d_addr;
  assign sel_wdata = i_win ? i_wdata : d_wdata;

  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;

  // Next-state, counters, read-data capture and all strobe/handshake outputs.
  always_comb begin
    state_next      = state_reg;
    lat_cnt_next    = lat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    owner_i_next    = owner_i_reg;
    i_rdata_next    = i_rdata_reg;
    d_rdata_next    = d_rdata_reg;

    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_err     = 1'b0;
    d_err     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_win || d_win) begin
          mem_addr     = sel_addr;
          mem_wdata    = sel_wdata;
          mem_wr       = sel_wr;
          mem_rd       = ~sel_wr;
          i_gnt        = i_win;
          d_gnt        = d_win;
          i_err        = i_win & mem_err;
          d_err        = d_win & mem_err;
          owner_i_next = i_win;

          // Writes and errored reads complete in the issue cycle.
          if (!sel_wr && !mem_err) begin
            state_next   = RD_WAIT;
            lat_cnt_next = LAT_LOAD;
          end

          if (i_win) begin
            starve_cnt_next = 4'd0;
          end else if (i_req && (starve_cnt_reg != STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
          end
        end
      end

      RD_WAIT: begin
        if (lat_cnt_reg == 3'd0) begin
          if (owner_i_reg) begin
            i_rdata_next = mem_rdata;
          end else begin
            d_rdata_next = mem_rdata;
          end
          state_next = RD_RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg - 3'd1;
        end
      end

      RD_RESP: begin
        i_rvalid   = owner_i_reg;
        d_rvalid   = ~owner_i_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state: FSM, latency counter, starvation counter and read owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= 3'd0;
      starve_cnt_reg <= 4'd0;
      owner_i_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lat_cnt_reg    <= lat_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      owner_i_reg    <= owner_i_next;
    end
  end

  // Returned read data per port; holds until the next capture for that port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_reg <= 16'h0000;
      d_rdata_reg <= 16'h0000;
    end else begin
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Instance dut runs RD_LAT=2 and carries
// the directed steps; instance dut1 runs RD_LAT=1 for the back-to-back reads.
// A small latency-exact memory model feeds mem_rdata for each instance, and
// per-port scoreboard queues hold the read data each rvalid must return.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance dut (RD_LAT=2)
  logic        i_req, i_wr, d_req, d_wr;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [3:0]  mem_busy;
  logic        mem_err;
  logic [15:0] mem_rdata;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata;

  // Instance dut1 (RD_LAT=1); port I tied off
  logic        d1_req, d1_wr;
  logic [15:0] d1_addr, d1_wdata;
  logic        z_req, z_wr;
  logic [15:0] z_addr, z_wdata;
  logic [3:0]  busy1;
  logic        err1;
  logic [15:0] mem_rdata1;
  logic        i1_gnt, i1_rvalid, i1_err, d1_gnt, d1_rvalid, d1_err;
  logic [15:0] i1_rdata, d1_rdata;
  logic        mem_rd1, mem_wr1;
  logic [15:0] mem_addr1, mem_wdata1;

  mem_arbiter #(.RD_LAT(2), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_err(mem_err)
  );

  mem_arbiter #(.RD_LAT(1), .STARVE_LIM(4)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(z_req), .i_wr(z_wr), .i_addr(z_addr), .i_wdata(z_wdata),
    .i_gnt(i1_gnt), .i_rvalid(i1_rvalid), .i_rdata(i1_rdata), .i_err(i1_err),
    .d_req(d1_req), .d_wr(d1_wr), .d_addr(d1_addr), .d_wdata(d1_wdata),
    .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata), .d_err(d1_err),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_busy(busy1), .mem_err(err1)
  );

  // Memory contents as seen by reads
  function automatic logic [15:0] data_of(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : {a[7:0] ^ 8'h3C, a[7:0]};
  endfunction

  // Read-latency model: data is valid only in the cycle RD_LAT after the strobe
  logic [16:0] p0a, p0b, p1a;
  always @(posedge clk) begin
    if (!rst) begin
      p0a <= 17'h0;
      p0b <= 17'h0;
      p1a <= 17'h0;
    end else begin
      p0a <= {mem_rd, data_of(mem_addr)};
      p0b <= p0a;
      p1a <= {mem_rd1, data_of(mem_addr1)};
    end
  end
  assign mem_rdata  = p0b[16] ? p0b[15:0] : 16'hDEAD;
  assign mem_rdata1 = p1a[16] ? p1a[15:0] : 16'hDEAD;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [15:0] q_i[$];
  logic [15:0] q_d[$];
  logic [15:0] q_d1[$];

  task automatic chk1(input string tag, input logic obs, input logic want);
    vec_cnt++;
    assert (obs === want) else begin
      miss_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] want);
    vec_cnt++;
    assert (obs === want) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Cycle monitor: exclusivity invariants and scoreboard pops on each rvalid
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk1("mon_rd_wr_excl", mem_rd & mem_wr, 1'b0);
      chk1("mon_gnt_excl", i_gnt & d_gnt, 1'b0);
      if (!mem_rd && !mem_wr) chk16("mon_idle_addr", mem_addr, 16'h0000);
      if (i_rvalid) begin
        if (q_i.size() == 0) chk1("mon_i_unexp_rvalid", i_rvalid, 1'b0);
        else chk16("mon_i_rdata", i_rdata, q_i.pop_front());
      end
      if (d_rvalid) begin
        if (q_d.size() == 0) chk1("mon_d_unexp_rvalid", d_rvalid, 1'b0);
        else chk16("mon_d_rdata", d_rdata, q_d.pop_front());
      end
      if (d1_rvalid) begin
        if (q_d1.size() == 0) chk1("mon_d1_unexp_rvalid", d1_rvalid, 1'b0);
        else chk16("mon_d1_rdata", d1_rdata, q_d1.pop_front());
      end
      chk1("mon_i1_rvalid", i1_rvalid, 1'b0);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic exp_i;
  int   n;

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_wr = 1'b0; i_addr = 16'h0; i_wdata = 16'h0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    mem_busy = 4'h0; mem_err = 1'b0;
    d1_req = 1'b0; d1_wr = 1'b0; d1_addr = 16'h0; d1_wdata = 16'h0;
    z_req = 1'b0; z_wr = 1'b0; z_addr = 16'h0; z_wdata = 16'h0;
    busy1 = 4'h0; err1 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_i_gnt", i_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk16("rst_i_rdata", i_rdata, 16'h0000);
    chk16("rst_d_rdata", d_rdata, 16'h0000);
    chk16("rst_d1_rdata", d1_rdata, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single D read of 0x0010, data returns three cycles after the grant
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    q_d.push_back(16'hBEEF);
    @(negedge clk);
    chk1("t1_d_gnt", d_gnt, 1'b1);
    chk1("t1_mem_rd", mem_rd, 1'b1);
    chk16("t1_mem_addr", mem_addr, 16'h0010);
    chk1("t1_i_gnt", i_gnt, 1'b0);
    @(posedge clk); #1;
    d_req = 1'b0; d_addr = 16'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk1("t1_d_rvalid", d_rvalid, k == 3);
      chk1("t1_i_rvalid", i_rvalid, 1'b0);
      chk1("t1_no_gnt", d_gnt | i_gnt, 1'b0);
      if (k >= 3) chk16("t1_d_rdata", d_rdata, 16'hBEEF);
    end
    @(posedge clk); #1;

    // 2: both ports hold read requests; I wins every fifth arbitration
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0002;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0004;
    for (int a = 0; a < 10; a++) begin
      exp_i = (a == 4) || (a == 9);
      if (exp_i) q_i.push_back(16'h3E02);
      else q_d.push_back(16'h3804);
      n = 0;
      @(negedge clk);
      while (!(i_gnt || d_gnt) && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk1("t2_gnt_seen", i_gnt | d_gnt, 1'b1);
      chk1("t2_i_win", i_gnt, exp_i);
      chk1("t2_d_win", d_gnt, !exp_i);
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk16("t2_queues_drained", 16'(q_i.size() + q_d.size()), 16'h0000);
    @(posedge clk); #1;

    // 3: D's bank busy, I writes bank 0 in the same cycle; D goes once bank frees
    mem_busy = 4'b0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0002;
    i_req = 1'b1; i_wr = 1'b1; i_addr = 16'h0008; i_wdata = 16'h1234;
    q_d.push_back(16'h3E02);
    @(negedge clk);
    chk1("t3_i_gnt", i_gnt, 1'b1);
    chk1("t3_d_gnt", d_gnt, 1'b0);
    chk1("t3_mem_wr", mem_wr, 1'b1);
    chk1("t3_mem_rd", mem_rd, 1'b0);
    chk16("t3_mem_addr", mem_addr, 16'h0008);
    chk16("t3_mem_wdata", mem_wdata, 16'h1234);
    @(posedge clk); #1;
    i_req = 1'b0; i_wr = 1'b0; i_addr = 16'h0; i_wdata = 16'h0;
    repeat (2) begin
      @(negedge clk);
      chk1("t3_d_held", d_gnt, 1'b0);
      chk1("t3_no_rd", mem_rd, 1'b0);
      @(posedge clk); #1;
    end
    mem_busy = 4'b0000;
    @(negedge clk);
    chk1("t3_d_gnt_free", d_gnt, 1'b1);
    chk16("t3_d_addr", mem_addr, 16'h0002);
    @(posedge clk); #1;
    d_req = 1'b0; d_addr = 16'h0;
    repeat (4) @(negedge clk);
    chk16("t3_queue_drained", 16'(q_d.size()), 16'h0000);
    @(posedge clk); #1;

    // 4a: I write with memory error -> gnt+err together, no read phase
    i_req = 1'b1; i_wr = 1'b1; i_addr = 16'h0006; i_wdata = 16'hAAAA; mem_err = 1'b1;
    @(negedge clk);
    chk1("t4_i_gnt", i_gnt, 1'b1);
    chk1("t4_i_err", i_err, 1'b1);
    chk1("t4_mem_wr", mem_wr, 1'b1);
    chk1("t4_d_err", d_err, 1'b0);
    @(posedge clk); #1;
    i_req = 1'b0; i_wr = 1'b0; i_addr = 16'h0; i_wdata = 16'h0; mem_err = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    q_d.push_back(16'hBEEF);
    @(negedge clk);
    chk1("t4_i_err_clear", i_err, 1'b0);
    chk1("t4_i_rvalid", i_rvalid, 1'b0);
    chk1("t4_idle_d_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0; d_addr = 16'h0;
    repeat (3) @(negedge clk);
    chk1("t4_d_rvalid", d_rvalid, 1'b1);
    @(posedge clk); #1;

    // 4b: D read with memory error -> err, no rvalid, arbiter free next cycle
    d_req = 1'b1; d_addr = 16'h0004; mem_err = 1'b1;
    @(negedge clk);
    chk1("t4b_d_gnt", d_gnt, 1'b1);
    chk1("t4b_d_err", d_err, 1'b1);
    chk1("t4b_mem_rd", mem_rd, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0; d_addr = 16'h0; mem_err = 1'b0;
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0002;
    q_i.push_back(16'h3E02);
    @(negedge clk);
    chk1("t4b_i_gnt_next", i_gnt, 1'b1);
    @(posedge clk); #1;
    i_req = 1'b0; i_addr = 16'h0;
    repeat (3) @(negedge clk);
    chk1("t4b_i_rvalid", i_rvalid, 1'b1);
    chk16("t4b_i_rdata", i_rdata, 16'h3E02);
    chk1("t4b_no_d_rvalid", d_rvalid, 1'b0);
    @(posedge clk); #1;

    // 5: reset asserted during RD_WAIT abandons the read
    d_req = 1'b1; d_addr = 16'h0010;
    q_d.push_back(16'hBEEF);
    @(negedge clk);
    chk1("t5_d_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    q_d.delete();
    #1;
    chk1("t5_rst_d_gnt", d_gnt, 1'b0);
    chk1("t5_rst_mem_rd", mem_rd, 1'b0);
    chk16("t5_rst_mem_addr", mem_addr, 16'h0000);
    chk16("t5_rst_d_rdata", d_rdata, 16'h0000);
    chk16("t5_rst_i_rdata", i_rdata, 16'h0000);
    @(negedge clk);
    chk1("t5_rst_hold_gnt", d_gnt, 1'b0);
    chk1("t5_rst_hold_rvalid", d_rvalid, 1'b0);
    @(posedge clk); #1;
    d_req = 1'b0; d_addr = 16'h0;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1("t5_no_rvalid", d_rvalid, 1'b0);
    end
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 16'h0002;
    q_d.push_back(16'h3E02);
    @(negedge clk);
    chk1("t5_after_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0; d_addr = 16'h0;
    repeat (3) @(negedge clk);
    chk1("t5_after_rvalid", d_rvalid, 1'b1);
    chk16("t5_after_rdata", d_rdata, 16'h3E02);
    @(posedge clk); #1;

    // 6: RD_LAT=1 back-to-back D reads, grants three cycles apart
    d1_req = 1'b1; d1_wr = 1'b0; d1_addr = 16'h0002;
    q_d1.push_back(16'h3E02);
    @(negedge clk);
    chk1("t6_gnt0", d1_gnt, 1'b1);
    chk16("t6_addr0", mem_addr1, 16'h0002);
    @(posedge clk); #1;
    d1_addr = 16'h0004;
    q_d1.push_back(16'h3804);
    @(negedge clk);
    chk1("t6_wait_gnt", d1_gnt, 1'b0);
    chk1("t6_wait_rvalid", d1_rvalid, 1'b0);
    @(negedge clk);
    chk1("t6_rvalid0", d1_rvalid, 1'b1);
    chk16("t6_rdata0", d1_rdata, 16'h3E02);
    chk1("t6_resp_gnt", d1_gnt, 1'b0);
    @(negedge clk);
    chk1("t6_gnt1", d1_gnt, 1'b1);
    chk16("t6_addr1", mem_addr1, 16'h0004);
    @(posedge clk); #1;
    d1_req = 1'b0; d1_addr = 16'h0;
    @(negedge clk);
    chk1("t6_wait1_rvalid", d1_rvalid, 1'b0);
    @(negedge clk);
    chk1("t6_rvalid1", d1_rvalid, 1'b1);
    chk16("t6_rdata1", d1_rdata, 16'h3804);

    repeat (2) @(negedge clk);
    chk16("final_queues_empty", 16'(q_i.size() + q_d.size() + q_d1.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
